inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Host-side instruction assembler that turns structured configuration commands into the 32-bit controller instruction stream, and writes that stream sequentially into instruction memory.
- It is the producer counterpart of the controller's instruction decoder.
- It splits wide fields (32-bit loop strides, 42-bit base/offset addresses) into the HI/LO or part-0/part-1 instruction pairs the decoder expects.
- It sits between the host config port and the IMEM write port, ahead of the controller start.

Parameters:
- IMEM_ADDR_W, 10, instruction memory address width.
- INST_W, 32, instruction width.
- DDR_ADDR_W, 42, base/offset address width; fixed at 2x21 bits.
- IMM_WIDTH, 16, immediate field width.
- LOOP_ID_W, 5, loop id field width.
- BUF_TYPE_W, 2, buffer id width.
- CMD_KIND_W, 4, command kind width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  clears write address, count and error flags; aborts any pending second word.
- cmd_v  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_v && cmd_ready.
- cmd_kind  in  CMD_KIND_W  command kind.
- cmd_buf_id  in  BUF_TYPE_W  target buffer.
- cmd_loop_id  in  LOOP_ID_W  loop id.
- cmd_sel  in  2  stride type, or last-block flag in bit 0 for BLOCK_END.
- cmd_value  in  DDR_ADDR_W  payload: iter, stride, size, address, PU count, or raw word in [31:0].
- imem_write_req  out  1  IMEM write strobe.
- imem_write_addr  out  IMEM_ADDR_W  IMEM write address.
- imem_write_data  out  INST_W  encoded instruction.
- inst_count  out  IMEM_ADDR_W+1  number of words written since start.
- overflow  out  1  sticky: a command was dropped for lack of space.
- bad_cmd  out  1  sticky: a command with an unknown kind was dropped.

Behaviour:
- Instruction word layout: {op_code[31:28], op_spec[27:21], loop_id[20:16], imm[15:0]}.
- op_spec layout: {1'b0, buf_id zero-extended to 3 bits, 1'b0, sel/part[1:0]}.
- Op codes: SETUP=0, LDMEM=1, STMEM=2, RDBUF=3, WRBUF=4, GENADDR_HI=5, GENADDR_LO=6, LOOP=7, BLOCK_END=8, BASE_ADDR=9, PU_BLOCK_START=10, DSP_MULTIPLEX=13.
- cmd_kind mapping:
  - 0 LOOP: op 7, imm = value[15:0].
  - 1 STRIDE: if value[31:16] != 0, emit GENADDR_HI (imm = value[31:16]) and then GENADDR_LO (imm = value[15:0]); otherwise emit LO only. sel goes into op_spec[1:0].
  - 2 LDMEM, 3 STMEM, 4 RDBUF, 5 WRBUF: one word, imm = value[15:0].
  - 6 BASE_ADDR: always two words. Part 0 carries {loop_id, imm} = value[20:0] with op_spec[1:0] = 0. Part 1 carries value[41:21] with op_spec[1:0] = 1. cmd_loop_id is ignored.
  - 7 OFFSET_ADDR: same as BASE_ADDR but uses op 13.
  - 8 PU_START: op 10, imm = value[15:0].
  - 9 RAW: word = value[31:0] unchanged.
  - 10 BLOCK_END: op 8, imm = {15'b0, sel[0]}.
  - 11..15: word dropped, bad_cmd set, cmd_ready stays high.
- FSM states:
  - S_IDLE: cmd_ready = 1.
  - S_SECOND: cmd_ready = 0. The registered second word is emitted on the next cycle, then the FSM returns to S_IDLE.
- Latency: a command accepted in cycle N produces its first word (req, addr, data all registered) in cycle N+1. A second word, if any, appears in cycle N+2. Back-to-back single-word commands sustain 1 word per cycle.
- Address: starts at 0 and increments by 1 per written word. inst_count tracks the number of words written.
- Capacity: before accepting, the block compares words needed against 2^IMEM_ADDR_W - inst_count. If space is insufficient, the whole command is dropped, nothing is written, overflow is set, and cmd_ready stays high. A pair is never split. A full IMEM (count = 1024) leaves the address at 1023 with no wrap.
- start (level, sampled each cycle): has priority over cmd_v in the same cycle, which means that command is not accepted. It returns the FSM to S_IDLE, drops any pending second word, and clears addr, inst_count, overflow and bad_cmd.
- Reset values: all outputs 0 except cmd_ready. cmd_ready is 0 during reset and 1 in the first cycle after reset.

Decomposition:
- Shared package inst_pkg holds:
  - the op code constants (shared with the decoder);
  - the cmd_kind constants;
  - the field positions and widths of the word layout.
- One natural sub-module, inst_pack: a combinational function (op, buf_id, sel, loop_id, imm) -> 32-bit word, instantiated for the first and second word.
- The FSM, counters and flags live in inst_encoder.

Test Plan:
- Single LOOP: loop_id=3, value=0x10 -> one write: addr 0, data 0x7003_0010, inst_count=1.
- STRIDE: buf 2, loop 1, sel 1, value 0x0002_0004 -> 0x5221_0002 at addr 0, then 0x6221_0004 at addr 1; cmd_ready low for exactly one cycle.
- STRIDE with value 0x4: LO word only, 0x6221_0004. Then BLOCK_END with sel=1 -> 0x8000_0001 at addr 1.
- BASE_ADDR: buf 0, value 0x200005 -> 0x9000_0005, then 0x9020_0001. OFFSET_ADDR with the same value -> 0xD000_0005, then 0xD020_0001.
- Capacity: fill to 1023 words with RAW, then issue BASE_ADDR -> no write, overflow=1, inst_count stays 1023. A following RAW 0xDEADBEEF is written at addr 1023 and inst_count becomes 1024.
- Abort: start asserted in the S_SECOND cycle of BASE_ADDR -> second word suppressed, inst_count=0, next command written at addr 0. cmd_kind=12 -> no write, bad_cmd=1; bad_cmd is cleared by start.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared constants for the controller instruction format: op codes, host command kinds
// and word field layout. The decoder imports the same package.
package inst_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int INST_W      = 32;
  localparam int DDR_ADDR_W  = 42;
  localparam int DDR_PART_W  = 21;
  localparam int IMM_WIDTH   = 16;
  localparam int LOOP_ID_W   = 5;
  localparam int BUF_TYPE_W  = 2;
  localparam int CMD_KIND_W  = 4;
  localparam int OP_CODE_W   = 4;
  localparam int OP_SPEC_W   = 7;
  localparam int SEL_W       = 2;
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

  // Word layout: {op_code[31:28], op_spec[27:21], loop_id[20:16], imm[15:0]}
  localparam int OP_CODE_LSB = 28;
  localparam int OP_SPEC_LSB = 21;
  localparam int LOOP_ID_LSB = 16;
  localparam int IMM_LSB     = 0;

  localparam logic [OP_CODE_W-1:0] OP_SETUP          = 4'd0;
  localparam logic [OP_CODE_W-1:0] OP_LDMEM          = 4'd1;
  localparam logic [OP_CODE_W-1:0] OP_STMEM          = 4'd2;
  localparam logic [OP_CODE_W-1:0] OP_RDBUF          = 4'd3;
  localparam logic [OP_CODE_W-1:0] OP_WRBUF          = 4'd4;
  localparam logic [OP_CODE_W-1:0] OP_GENADDR_HI     = 4'd5;
  localparam logic [OP_CODE_W-1:0] OP_GENADDR_LO     = 4'd6;
  localparam logic [OP_CODE_W-1:0] OP_LOOP           = 4'd7;
  localparam logic [OP_CODE_W-1:0] OP_BLOCK_END      = 4'd8;
  localparam logic [OP_CODE_W-1:0] OP_BASE_ADDR      = 4'd9;
  localparam logic [OP_CODE_W-1:0] OP_PU_BLOCK_START = 4'd10;
  localparam logic [OP_CODE_W-1:0] OP_DSP_MULTIPLEX  = 4'd13;

  localparam logic [CMD_KIND_W-1:0] KIND_LOOP        = 4'd0;
  localparam logic [CMD_KIND_W-1:0] KIND_STRIDE      = 4'd1;
  localparam logic [CMD_KIND_W-1:0] KIND_LDMEM       = 4'd2;
  localparam logic [CMD_KIND_W-1:0] KIND_STMEM       = 4'd3;
  localparam logic [CMD_KIND_W-1:0] KIND_RDBUF       = 4'd4;
  localparam logic [CMD_KIND_W-1:0] KIND_WRBUF       = 4'd5;
  localparam logic [CMD_KIND_W-1:0] KIND_BASE_ADDR   = 4'd6;
  localparam logic [CMD_KIND_W-1:0] KIND_OFFSET_ADDR = 4'd7;
  localparam logic [CMD_KIND_W-1:0] KIND_PU_START    = 4'd8;
  localparam logic [CMD_KIND_W-1:0] KIND_RAW         = 4'd9;
  localparam logic [CMD_KIND_W-1:0] KIND_BLOCK_END   = 4'd10;

  // Words a command expands to; 0 marks an unknown kind.
  function automatic logic [1:0] kind_words(input logic [CMD_KIND_W-1:0] kind,
                                            input logic stride_hi_nz);
    logic [1:0] n;
    n = 2'd1;
    if (kind > KIND_BLOCK_END) begin
      n = 2'd0;
    end else if (kind == KIND_BASE_ADDR || kind == KIND_OFFSET_ADDR) begin
      n = 2'd2;
    end else if (kind == KIND_STRIDE && stride_hi_nz) begin
      n = 2'd2;
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Host command port plus IMEM write port of the instruction encoder.
interface inst_encoder_if;
  import inst_pkg::*;

  // A command transfers on every cycle where cmd_v && cmd_ready; cmd_* must be held
  // stable while cmd_v is high and not yet accepted. imem_write_req is a one-cycle strobe.
  logic                   cmd_v;
  logic                   cmd_ready;
  logic [CMD_KIND_W-1:0]  cmd_kind;
  logic [BUF_TYPE_W-1:0]  cmd_buf_id;
  logic [LOOP_ID_W-1:0]   cmd_loop_id;
  logic [SEL_W-1:0]       cmd_sel;
  logic [DDR_ADDR_W-1:0]  cmd_value;

  logic                   imem_write_req;
  logic [IMEM_ADDR_W-1:0] imem_write_addr;
  logic [INST_W-1:0]      imem_write_data;

  modport master (
    output cmd_v, cmd_kind, cmd_buf_id, cmd_loop_id, cmd_sel, cmd_value,
    input  cmd_ready, imem_write_req, imem_write_addr, imem_write_data
  );

  modport slave (
    input  cmd_v, cmd_kind, cmd_buf_id, cmd_loop_id, cmd_sel, cmd_value,
    output cmd_ready, imem_write_req, imem_write_addr, imem_write_data
  );

endinterface

// File: rtl/inst_encoder_pack.sv
// Packs instruction fields into one 32-bit controller word.
module inst_pack
  import inst_pkg::*;
(
  input  logic [OP_CODE_W-1:0]  op,
  input  logic [BUF_TYPE_W-1:0] buf_id,
  input  logic [SEL_W-1:0]      sel,
  input  logic [LOOP_ID_W-1:0]  loop_id,
  input  logic [IMM_WIDTH-1:0]  imm,
  output logic [INST_W-1:0]     word
);

  logic [OP_SPEC_W-1:0] op_spec;

  // op_spec = {1'b0, buf_id zero-extended to 3 bits, 1'b0, sel}
  assign op_spec = {2'b00, buf_id, 1'b0, sel};
  assign word    = {op, op_spec, loop_id, imm};

endmodule

// File: rtl/inst_encoder.sv
// Host-side instruction assembler: expands config commands into controller words and
// writes them sequentially into IMEM, splitting wide fields into word pairs.
module inst_encoder
  import inst_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  inst_encoder_if.slave        bus,
  output logic [IMEM_ADDR_W:0] inst_count,
  output logic                 overflow,
  output logic                 bad_cmd,
  output logic [0:0]           dbg_state
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SECOND = 1'b1;

  localparam logic [IMEM_ADDR_W:0] DEPTH_C = (IMEM_ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [IMEM_ADDR_W:0] ONE_C   = (IMEM_ADDR_W+1)'(1);

  logic [0:0]             state_q;
  logic                   req_q;
  logic [IMEM_ADDR_W-1:0] addr_q;
  logic [INST_W-1:0]      data_q;
  logic [INST_W-1:0]      second_q;
  logic [IMEM_ADDR_W:0]   count_q;
  logic                   overflow_q;
  logic                   bad_q;

  logic [OP_CODE_W-1:0]  op0, op1;
  logic [BUF_TYPE_W-1:0] buf0;
  logic [SEL_W-1:0]      sel0, sel1;
  logic [LOOP_ID_W-1:0]  loop0, loop1;
  logic [IMM_WIDTH-1:0]  imm0, imm1;
  logic                  raw;
  logic                  stride_hi_nz;
  logic [1:0]            words_needed;
  logic [IMEM_ADDR_W:0]  space;
  logic                  fits;
  logic                  accept;
  logic [INST_W-1:0]     packed0, packed1, word0;

  assign stride_hi_nz = (bus.cmd_value[31:16] != 16'd0);
  assign words_needed = kind_words(bus.cmd_kind, stride_hi_nz);

  always_comb begin
    op0   = OP_SETUP;
    op1   = OP_SETUP;
    buf0  = bus.cmd_buf_id;
    sel0  = bus.cmd_sel;
    sel1  = bus.cmd_sel;
    loop0 = bus.cmd_loop_id;
    loop1 = bus.cmd_loop_id;
    imm0  = bus.cmd_value[15:0];
    imm1  = bus.cmd_value[15:0];
    raw   = 1'b0;
    case (bus.cmd_kind)
      KIND_LOOP:     op0 = OP_LOOP;
      KIND_STRIDE: begin
        if (stride_hi_nz) begin
          op0  = OP_GENADDR_HI;
          imm0 = bus.cmd_value[31:16];
          op1  = OP_GENADDR_LO;
        end else begin
          op0 = OP_GENADDR_LO;
        end
      end
      KIND_LDMEM:    op0 = OP_LDMEM;
      KIND_STMEM:    op0 = OP_STMEM;
      KIND_RDBUF:    op0 = OP_RDBUF;
      KIND_WRBUF:    op0 = OP_WRBUF;
      KIND_BASE_ADDR, KIND_OFFSET_ADDR: begin
        // 42-bit address split into two 21-bit parts carried in {loop_id, imm}
        op0 = (bus.cmd_kind == KIND_BASE_ADDR) ? OP_BASE_ADDR : OP_DSP_MULTIPLEX;
        op1 = op0;
        sel0 = 2'd0;
        sel1 = 2'd1;
        {loop0, imm0} = bus.cmd_value[DDR_PART_W-1:0];
        {loop1, imm1} = bus.cmd_value[DDR_ADDR_W-1:DDR_PART_W];
      end
      KIND_PU_START: op0 = OP_PU_BLOCK_START;
      KIND_RAW:      raw = 1'b1;
      KIND_BLOCK_END: begin
        op0   = OP_BLOCK_END;
        buf0  = '0;
        sel0  = 2'd0;
        loop0 = '0;
        imm0  = {15'd0, bus.cmd_sel[0]};
      end
      default: ;
    endcase
  end

  inst_pack u_pack0 (
    .op      (op0),
    .buf_id  (buf0),
    .sel     (sel0),
    .loop_id (loop0),
    .imm     (imm0),
    .word    (packed0)
  );

  inst_pack u_pack1 (
    .op      (op1),
    .buf_id  (bus.cmd_buf_id),
    .sel     (sel1),
    .loop_id (loop1),
    .imm     (imm1),
    .word    (packed1)
  );

  assign word0 = raw ? bus.cmd_value[INST_W-1:0] : packed0;

  // Capacity is checked for the whole command so a pair is never split.
  assign space  = DEPTH_C - count_q;
  assign fits   = ((IMEM_ADDR_W+1)'(words_needed) <= space);

  assign bus.cmd_ready = !reset && !start && (state_q == S_IDLE);
  assign accept        = bus.cmd_v && bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      second_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (words_needed == 2'd0) begin
              bad_q <= 1'b1;
            end else if (!fits) begin
              overflow_q <= 1'b1;
            end else begin
              req_q   <= 1'b1;
              addr_q  <= count_q[IMEM_ADDR_W-1:0];
              data_q  <= word0;
              count_q <= count_q + ONE_C;
              if (words_needed == 2'd2) begin
                second_q <= packed1;
                state_q  <= S_SECOND;
              end
            end
          end
        end
        S_SECOND: begin
          req_q   <= 1'b1;
          addr_q  <= count_q[IMEM_ADDR_W-1:0];
          data_q  <= second_q;
          count_q <= count_q + ONE_C;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_write_req  = req_q;
  assign bus.imem_write_addr = addr_q;
  assign bus.imem_write_data = data_q;
  assign inst_count          = count_q;
  assign overflow            = overflow_q;
  assign bad_cmd             = bad_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed instruction words, latency, capacity
// limit, start abort and unknown-kind handling.
module tb_inst_encoder;
  import inst_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [IMEM_ADDR_W:0] inst_count;
  logic                 overflow;
  logic                 bad_cmd;
  logic [0:0]           dbg_state;

  int checks   = 0;
  int failures = 0;

  inst_encoder_if bus();

  inst_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .inst_count (inst_count),
    .overflow   (overflow),
    .bad_cmd    (bad_cmd),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] kind, input logic [1:0] b, input logic [4:0] l,
                      input logic [1:0] s, input logic [41:0] v);
    bus.cmd_kind    = kind;
    bus.cmd_buf_id  = b;
    bus.cmd_loop_id = l;
    bus.cmd_sel     = s;
    bus.cmd_value   = v;
    bus.cmd_v       = 1'b1;
    tick();
    bus.cmd_v       = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.cmd_v = 1'b0;
    bus.cmd_kind = '0;
    bus.cmd_buf_id = '0;
    bus.cmd_loop_id = '0;
    bus.cmd_sel = '0;
    bus.cmd_value = '0;
    repeat (3) tick();
    check("rst_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_req", 64'(bus.imem_write_req), 64'd0);
    check("rst_count", 64'(inst_count), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
    check("post_rst_addr", 64'(bus.imem_write_addr), 64'd0);
    check("post_rst_data", 64'(bus.imem_write_data), 64'd0);
    check("post_rst_flags", 64'({overflow, bad_cmd}), 64'd0);

    // single LOOP
    send(KIND_LOOP, 2'd0, 5'd3, 2'd0, 42'h10);
    check("loop_req", 64'(bus.imem_write_req), 64'd1);
    check("loop_addr", 64'(bus.imem_write_addr), 64'd0);
    check("loop_data", 64'(bus.imem_write_data), 64'h7003_0010);
    check("loop_count", 64'(inst_count), 64'd1);
    tick();
    check("loop_req_drop", 64'(bus.imem_write_req), 64'd0);

    // start wins over a same-cycle command and clears the count
    bus.cmd_kind = KIND_LOOP;
    bus.cmd_value = 42'h55;
    bus.cmd_v = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.cmd_v = 1'b0;
    check("start_prio_req", 64'(bus.imem_write_req), 64'd0);
    check("start_count", 64'(inst_count), 64'd0);

    // STRIDE with HI part
    send(KIND_STRIDE, 2'd2, 5'd1, 2'd1, 42'h0002_0004);
    check("stride_hi_data", 64'(bus.imem_write_data), 64'h5221_0002);
    check("stride_hi_addr", 64'(bus.imem_write_addr), 64'd0);
    check("stride_ready_low", 64'(bus.cmd_ready), 64'd0);
    check("stride_state", 64'(dbg_state), 64'd1);
    tick();
    check("stride_lo_req", 64'(bus.imem_write_req), 64'd1);
    check("stride_lo_data", 64'(bus.imem_write_data), 64'h6221_0004);
    check("stride_lo_addr", 64'(bus.imem_write_addr), 64'd1);
    check("stride_ready_back", 64'(bus.cmd_ready), 64'd1);
    check("stride_count", 64'(inst_count), 64'd2);
    pulse_start();

    // STRIDE LO only, then back-to-back BLOCK_END
    send(KIND_STRIDE, 2'd2, 5'd1, 2'd1, 42'h4);
    check("lo_only_data", 64'(bus.imem_write_data), 64'h6221_0004);
    check("lo_only_ready", 64'(bus.cmd_ready), 64'd1);
    send(KIND_BLOCK_END, 2'd0, 5'd0, 2'd1, 42'h0);
    check("blkend_req", 64'(bus.imem_write_req), 64'd1);
    check("blkend_addr", 64'(bus.imem_write_addr), 64'd1);
    check("blkend_data", 64'(bus.imem_write_data), 64'h8000_0001);
    pulse_start();

    // BASE_ADDR then OFFSET_ADDR; cmd_loop_id must be ignored
    send(KIND_BASE_ADDR, 2'd0, 5'd7, 2'd3, 42'h20_0005);
    check("base_p0_data", 64'(bus.imem_write_data), 64'h9000_0005);
    tick();
    check("base_p1_data", 64'(bus.imem_write_data), 64'h9020_0001);
    check("base_p1_addr", 64'(bus.imem_write_addr), 64'd1);
    send(KIND_OFFSET_ADDR, 2'd0, 5'd7, 2'd3, 42'h20_0005);
    check("ofs_p0_data", 64'(bus.imem_write_data), 64'hD000_0005);
    check("ofs_p0_addr", 64'(bus.imem_write_addr), 64'd2);
    tick();
    check("ofs_p1_data", 64'(bus.imem_write_data), 64'hD020_0001);
    check("ofs_count", 64'(inst_count), 64'd4);
    pulse_start();

    // abort in S_SECOND
    send(KIND_BASE_ADDR, 2'd0, 5'd0, 2'd0, 42'h20_0005);
    check("abort_p0_data", 64'(bus.imem_write_data), 64'h9000_0005);
    pulse_start();
    check("abort_req", 64'(bus.imem_write_req), 64'd0);
    check("abort_count", 64'(inst_count), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    send(KIND_LOOP, 2'd0, 5'd1, 2'd0, 42'h22);
    check("after_abort_addr", 64'(bus.imem_write_addr), 64'd0);
    check("after_abort_data", 64'(bus.imem_write_data), 64'h7001_0022);

    // unknown kind
    send(4'd12, 2'd0, 5'd0, 2'd0, 42'h1);
    check("bad_req", 64'(bus.imem_write_req), 64'd0);
    check("bad_flag", 64'(bad_cmd), 64'd1);
    check("bad_count", 64'(inst_count), 64'd1);
    check("bad_ready", 64'(bus.cmd_ready), 64'd1);
    pulse_start();
    check("bad_cleared", 64'(bad_cmd), 64'd0);

    // capacity
    for (int i = 0; i < 1023; i++) send(KIND_RAW, 2'd0, 5'd0, 2'd0, 42'(i));
    check("fill_addr", 64'(bus.imem_write_addr), 64'd1022);
    check("fill_data", 64'(bus.imem_write_data), 64'd1022);
    check("fill_count", 64'(inst_count), 64'd1023);
    send(KIND_BASE_ADDR, 2'd0, 5'd0, 2'd0, 42'h20_0005);
    check("ovf_req", 64'(bus.imem_write_req), 64'd0);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_count", 64'(inst_count), 64'd1023);
    check("ovf_ready", 64'(bus.cmd_ready), 64'd1);
    send(KIND_RAW, 2'd0, 5'd0, 2'd0, 42'hDEAD_BEEF);
    check("last_req", 64'(bus.imem_write_req), 64'd1);
    check("last_addr", 64'(bus.imem_write_addr), 64'd1023);
    check("last_data", 64'(bus.imem_write_data), 64'hDEAD_BEEF);
    check("full_count", 64'(inst_count), 64'd1024);
    send(KIND_RAW, 2'd0, 5'd0, 2'd0, 42'h1);
    check("full_req", 64'(bus.imem_write_req), 64'd0);
    check("full_addr", 64'(bus.imem_write_addr), 64'd1023);
    check("full_count_hold", 64'(inst_count), 64'd1024);
    pulse_start();
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_addr", 64'(bus.imem_write_addr), 64'd0);
    check("clr_count", 64'(inst_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
